csa_result_fifo: RTL and testbench

//  Downstream capture stage for the 64-bit carry-select adder. Registers each
//  sum/c_out produced by the combinational adder when the producer asserts
//  in_valid. Derives status flags (zero, negative, signed overflow) and

---
 rtl/csa_result_fifo_if.sv | 30 +++
 rtl/csa_result_fifo.sv | 108 ++++++++++
 tb/tb_csa_result_fifo.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csa_result_fifo_if.sv
// Handshake bundle between the carry-select adder, its result FIFO and the consumer.
// Carries the push side (adder outputs plus operand MSBs) and the pop side (head entry with flags).
// The master drives push data and pop acceptance; the slave (the FIFO) drives ready, valid and head data.
interface csa_result_fifo_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             a_msb;
    logic             b_msb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_zero;
    logic             out_neg;
    logic             out_ovf;

    modport master (
        output in_valid, sum, c_out, a_msb, b_msb, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf
    );

    modport slave (
        input  in_valid, sum, c_out, a_msb, b_msb, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_zero, out_neg, out_ovf
    );
endinterface

// File: rtl/csa_result_fifo.sv
// Captures adder sum/c_out with zero/neg/ovf flags into a first-word-fall-through FIFO.
// Latency: an entry pushed at edge N is at the head after edge N; there is no same-cycle bypass.
// Backpressure: in_ready drops when full, from registered state only (a same-cycle pop frees nothing);
// the head holds while out_ready is low.
// Optional macro STICKY_OVF_EN adds the ovf_sticky output and the ovf_clr input.
module csa_result_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    csa_result_fifo_if.slave         bus,
`ifdef STICKY_OVF_EN
    output logic                     ovf_sticky,
    input  logic                     ovf_clr,
`endif
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } entry_t;

    entry_t          mem [DEPTH];
    entry_t          wr_ent;
    entry_t          head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_nxt;
    logic            ready_q;
    logic            not_empty;
    logic            push;
    logic            pop;

    assign not_empty = (count != '0);
    assign push      = bus.in_valid && ready_q;
    assign pop       = not_empty && bus.out_ready;

    // Flags are derived from the incoming sum so they travel with the entry.
    always_comb begin
        wr_ent      = '0;
        wr_ent.sum  = bus.sum;
        wr_ent.cout = bus.c_out;
        wr_ent.zero = (bus.sum == '0);
        wr_ent.neg  = bus.sum[WIDTH-1];
        wr_ent.ovf  = (bus.a_msb == bus.b_msb) && (bus.sum[WIDTH-1] != bus.a_msb);
    end

    // Occupancy for the next cycle; push and pop together leave it unchanged.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and the registered ready flag; ready is low during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count   <= count_nxt;
            ready_q <= (count_nxt != CW'(DEPTH));
        end
    end

    // Entry storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_ent;
    end

    // Head is read straight from storage and blanked when the FIFO is empty.
    always_comb begin
        head          = mem[rd_ptr];
        bus.in_ready  = ready_q;
        bus.out_valid = not_empty;
        bus.out_sum   = not_empty ? head.sum  : '0;
        bus.out_cout  = not_empty ? head.cout : 1'b0;
        bus.out_zero  = not_empty ? head.zero : 1'b0;
        bus.out_neg   = not_empty ? head.neg  : 1'b0;
        bus.out_ovf   = not_empty ? head.ovf  : 1'b0;
    end

`ifdef STICKY_OVF_EN
    // Sticky overflow: a push with ovf set wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_sticky <= 1'b0;
        else if (push && wr_ent.ovf)
            ovf_sticky <= 1'b1;
        else if (ovf_clr)
            ovf_sticky <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_csa_result_fifo.sv
module tb_csa_result_fifo;
    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             zero;
        logic             neg;
        logic             ovf;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [2:0] count;
`ifdef STICKY_OVF_EN
    logic       ovf_sticky;
    logic       ovf_clr;
`endif

    csa_result_fifo_if #(.WIDTH(WIDTH)) bus ();

    csa_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
`ifdef STICKY_OVF_EN
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr),
`endif
        .count      (count)
    );

    int   checks;
    int   failures;
    exp_t sbq[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(logic [WIDTH-1:0] s, logic c, logic a, logic b);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.zero = (s == 64'd0);
        e.neg  = s[WIDTH-1];
        e.ovf  = (a == b) && (s[WIDTH-1] != a);
        return e;
    endfunction

    task automatic drive(logic v, logic [WIDTH-1:0] s, logic c, logic a, logic b);
        bus.in_valid = v;
        bus.sum      = s;
        bus.c_out    = c;
        bus.a_msb    = a;
        bus.b_msb    = b;
    endtask

    // One clock: scoreboard pop on a handshake, record an accepted push, then advance.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL scoreboard_pop: unexpected output sum=%h, none expected", bus.out_sum);
            end else begin
                e = sbq.pop_front();
                if ({bus.out_sum, bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf} !== e) begin
                    failures++;
                    $display("FAIL scoreboard_data: got sum=%h c=%b z=%b n=%b o=%b, want sum=%h c=%b z=%b n=%b o=%b",
                             bus.out_sum, bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf,
                             e.sum, e.cout, e.zero, e.neg, e.ovf);
                end
            end
        end
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1)
            sbq.push_back(model(bus.sum, bus.c_out, bus.a_msb, bus.b_msb));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: count=%0d out_valid=%b in_ready=%b want 0/0/1",
                     count, bus.out_valid, bus.in_ready);
        end
        checks++;
        if ({bus.out_sum, bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: sum=%h c=%b z=%b n=%b o=%b want all 0",
                     bus.out_sum, bus.out_cout, bus.out_zero, bus.out_neg, bus.out_ovf);
        end
    endtask

    task automatic test_zero_flags();
        bus.out_ready = 1'b0;
        drive(1'b1, 64'd0, 1'b1, 1'b1, 1'b1);
        step();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_zero !== 1'b1 || bus.out_cout !== 1'b1 ||
            bus.out_ovf !== 1'b1 || bus.out_neg !== 1'b0) begin
            failures++;
            $display("FAIL zero_flags: v=%b z=%b c=%b o=%b n=%b want 1/1/1/1/0",
                     bus.out_valid, bus.out_zero, bus.out_cout, bus.out_ovf, bus.out_neg);
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0 || count !== 3'd0) begin
            failures++;
            $display("FAIL zero_drain: left=%0d count=%0d want 0/0", sbq.size(), count);
        end
    endtask

    task automatic test_ovf_flags();
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (bus.out_ovf !== 1'b0 || bus.out_neg !== 1'b0 || count !== 3'd2) begin
            failures++;
            $display("FAIL max_pos_flags: o=%b n=%b count=%0d want 0/0/2", bus.out_ovf, bus.out_neg, count);
        end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_ovf !== 1'b1 || bus.out_neg !== 1'b1 || bus.out_sum !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL min_neg_flags: o=%b n=%b sum=%h want 1/1/8000000000000000",
                     bus.out_ovf, bus.out_neg, bus.out_sum);
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL ovf_drain: left=%0d want 0", sbq.size());
        end
    endtask

    task automatic test_full();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        checks++;
        if (bus.in_ready !== 1'b0 || count !== 3'd4 || sbq.size() != 4) begin
            failures++;
            $display("FAIL full_state: in_ready=%b count=%0d accepted=%0d want 0/4/4",
                     bus.in_ready, count, sbq.size());
        end
        step();
        checks++;
        if (count !== 3'd4) begin
            failures++;
            $display("FAIL full_hold: count=%0d want 4", count);
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0 || count !== 3'd0 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL full_drain: left=%0d count=%0d out_valid=%b want 0/0/0",
                     sbq.size(), count, bus.out_valid);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (count !== 3'd0) begin
            failures++;
            $display("FAIL empty_pop: count=%0d want 0", count);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] second;
        bus.out_ready = 1'b0;
        drive(1'b1, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 1'b1);
        step();
        second = 64'h5555_6666_7777_8888;
        drive(1'b1, second, 1'b1, 1'b1, 1'b0);
        step();
        drive(1'b1, 64'h9999_AAAA_BBBB_CCCC, 1'b0, 1'b1, 1'b1);
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (count !== 3'd2 || bus.out_sum !== second) begin
            failures++;
            $display("FAIL push_pop_same_edge: count=%0d head=%h want 2/%h", count, bus.out_sum, second);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        checks++;
        if (count !== 3'd2) begin
            failures++;
            $display("FAIL wrap_count: count=%0d want 2", count);
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
        checks++;
        if (sbq.size() != 0 || count !== 3'd0) begin
            failures++;
            $display("FAIL wrap_drain: left=%0d count=%0d want 0/0", sbq.size(), count);
        end
    endtask

    task automatic test_mid_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'd100 + 64'(i), 1'b0, 1'b0, 1'b0);
            step();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (count !== 3'd3) begin
            failures++;
            $display("FAIL pre_reset_count: count=%0d want 3", count);
        end
        rst_n = 1'b0;
        step();
        sbq.delete();
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: count=%0d out_valid=%b in_ready=%b want 0/0/0",
                     count, bus.out_valid, bus.in_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_sum !== 64'd0) begin
            failures++;
            $display("FAIL post_reset: in_ready=%b out_sum=%h want 1/0", bus.in_ready, bus.out_sum);
        end
    endtask

`ifdef STICKY_OVF_EN
    task automatic test_sticky();
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_reset: got %b want 0", ovf_sticky);
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 64'd5, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_hold: got %b want 1", ovf_sticky);
        end
        ovf_clr = 1'b1;
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b0);
        step();
        checks++;
        if (ovf_sticky !== 1'b1) begin
            failures++;
            $display("FAIL sticky_set_wins: got %b want 1", ovf_sticky);
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
        step();
        ovf_clr = 1'b0;
        checks++;
        if (ovf_sticky !== 1'b0) begin
            failures++;
            $display("FAIL sticky_clear: got %b want 0", ovf_sticky);
        end
        for (int n = 0; n < 10 && sbq.size() != 0; n++) step();
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0);
`ifdef STICKY_OVF_EN
        ovf_clr = 1'b0;
`endif
        test_reset();
        test_zero_flags();
        test_ovf_flags();
        test_full();
        test_back_to_back();
        test_mid_reset();
`ifdef STICKY_OVF_EN
        test_sticky();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
